lru_burst_arbiter: RTL and testbench
====================================

Name: lru_burst_arbiter

Overview:
N-requester arbiter for the crossbar. Each requester holds a one-hot priority rank, and the highest-ranked active requester wins. The grant is locked for a whole burst and released only on the last-beat handshake. When the burst completes, the ranks are updated in least-recently-granted order (LRU), or left frozen for fixed-priority operation. One instance sits in front of each crossbar destination port.

Parameters:
N_REQ, 8, number of requesters (>=2)
IDX_W, $clog2(N_REQ), width of the encoded grant index (derived; do not override)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
req  input  N_REQ  per-requester valid
last  input  N_REQ  per-requester last-beat flag, qualifies the current beat
down_ready  input  1  downstream ready for the granted requester
lru_en  input  1  1 = LRU rank update at burst end; 0 = ranks frozen (fixed priority)
gnt  output  N_REQ  one-hot grant, registered
gnt_idx  output  IDX_W  encoded index of gnt, registered
gnt_valid  output  1  high while a grant is locked
xfer_done  output  1  one-cycle pulse, cycle after last-beat handshake
rank_o  output  N_REQ*N_REQ  debug: rank of requester i at [i*N_REQ +: N_REQ]

Behaviour:
- Reset (rstn=0 at posedge):
  - rank[i] = 1<<i, so requester N_REQ-1 has the highest priority.
  - State = IDLE.
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, xfer_done = 0.
- Rank invariant: the ranks always form a permutation of {1,2,4,...,2^(N_REQ-1)}. Larger value means higher priority.
- States: IDLE, LOCKED.
- IDLE:
  - If |req, winner w = argmax rank[i] over i with req[i]=1.
  - At the next edge: gnt = onehot(w), gnt_idx = w, gnt_valid = 1, state goes to LOCKED.
  - Latency from req to gnt is 1 cycle.
  - If req = 0, remain in IDLE with outputs 0.
- LOCKED:
  - gnt, gnt_idx and w are held.
  - Beat handshake = req[w] & down_ready.
  - Handshake with last[w] = 1 means burst end. At the next edge:
    - gnt = 0, gnt_valid = 0, state goes to IDLE.
    - xfer_done = 1 for exactly that one cycle.
    - Ranks update if lru_en = 1; lru_en is sampled in the burst-end cycle.
  - Handshake with last[w] = 0: the grant is held and the burst continues.
  - req[w] deasserting mid-burst (protocol violation): the grant is held, with no timeout.
  - Requests from other requesters are ignored while LOCKED.
- Bubble: at least one IDLE cycle always separates consecutive grants. Re-arbitration uses the already-updated ranks.
- LRU update, with r_w = rank[w], applied for each i in the same edge:
  - rank[i] == r_w: set to 1.
  - rank[i] > r_w: hold.
  - rank[i] < r_w: shift left by 1.
- lru_en = 0: ranks are never modified.
- xfer_done is 0 in every other cycle.
- Reset mid-burst: grant and ranks return to their reset values at that edge, and no xfer_done is issued.
- gnt_idx must always equal the encoding of gnt while gnt_valid = 1.

Test Plan:
- N_REQ=4, after reset: rank_o shows 1,2,4,8 for requesters 0..3. Drive req=0101 -> one cycle later gnt=0100, gnt_idx=2, gnt_valid=1.
- Continuing: single-beat burst from requester 2 (down_ready=1, last[2]=1, lru_en=1) -> next cycle gnt=0, xfer_done=1, ranks r0=2, r1=4, r2=1, r3=8.
- Multi-beat lock: requester 1 granted, req=1111 held, down_ready pattern 1,0,1,0,1 with last[1] on the third accepted beat -> gnt stays 0010 through that handshake, and requester 3 is not granted until after the IDLE bubble.
- Fairness: req=1111 constant, single-beat bursts, lru_en=1, from reset -> grant sequence 3,2,1,0,3,2, with one IDLE cycle between grants.
- Fixed mode: lru_en=0, req=1001 constant, single-beat bursts -> requester 3 wins every arbitration, and rank_o never changes.
- Reset mid-burst: rstn=0 during beat 2 of a 4-beat grant to requester 2 -> next cycle gnt=0, gnt_valid=0, xfer_done=0, ranks 1,2,4,8.

Source files
------------

// File: rtl/lru_burst_arbiter.sv
// Burst-locking arbiter for one crossbar destination port. The highest one-hot rank
// wins, the grant is held until the last-beat handshake, then ranks rotate LRU or stay frozen.
module lru_burst_arbiter #(
  parameter  int N_REQ = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic                     down_ready,
  input  logic                     lru_en,
  output logic [N_REQ-1:0]         gnt,
  output logic [IDX_W-1:0]         gnt_idx,
  output logic                     gnt_valid,
  output logic                     xfer_done,
  output logic [N_REQ*N_REQ-1:0]   rank_o
);

  // state  | meaning
  // IDLE   | no grant; arbitrate among active requesters each cycle
  // LOCKED | grant held for gnt_idx until its last-beat handshake
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [N_REQ-1:0] rank     [N_REQ];
  logic [N_REQ-1:0] rank_lru [N_REQ];
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_rank;
  logic [N_REQ-1:0] rank_w;
  logic             hs;
  logic             burst_end;

  always_comb begin
    win_idx  = '0;
    win_rank = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (rank[i] > win_rank)) begin
        win_rank = rank[i];
        win_idx  = IDX_W'(i);
      end
    end
  end

  assign hs        = req[gnt_idx] & down_ready;
  assign burst_end = hs & last[gnt_idx];
  assign rank_w    = rank[gnt_idx];

  // Winner drops to lowest rank; everything that was below it moves up one place.
  always_comb begin
    rank_lru = rank;
    for (int i = 0; i < N_REQ; i++) begin
      if (rank[i] == rank_w)
        rank_lru[i] = N_REQ'(1);
      else if (rank[i] > rank_w)
        rank_lru[i] = rank[i];
      else
        rank_lru[i] = rank[i] << 1;
    end
  end

  always_comb begin
    rank_o = '0;
    for (int i = 0; i < N_REQ; i++)
      rank_o[i*N_REQ +: N_REQ] = rank[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      xfer_done <= 1'b0;
      for (int i = 0; i < N_REQ; i++)
        rank[i] <= N_REQ'(1) << i;
    end else begin
      xfer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= N_REQ'(1) << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (burst_end) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            xfer_done <= 1'b1;
            state     <= IDLE;
            if (lru_en)
              rank <= rank_lru;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_burst_arbiter.sv
// Self-checking bench for lru_burst_arbiter with N_REQ=4: a vector table plus
// fairness / fixed-priority sequences, checked through an expectation queue.
module tb_lru_burst_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rstn;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         down_ready;
  logic         lru_en;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic         xfer_done;
  logic [N*N-1:0] rank_o;

  lru_burst_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rstn(rstn), .req(req), .last(last), .down_ready(down_ready),
    .lru_en(lru_en), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
    .xfer_done(xfer_done), .rank_o(rank_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] last;
    logic       dr;
    logic       lru;
  } stim_t;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  idx;
    logic        valid;
    logic        done;
    logic [15:0] rank;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic stim_t S(logic r, logic [3:0] q, logic [3:0] l, logic d, logic u);
    stim_t s;
    s.rstn = r; s.req = q; s.last = l; s.dr = d; s.lru = u;
    return s;
  endfunction

  function automatic exp_t E(logic [3:0] g, logic [1:0] i, logic v, logic dn, logic [15:0] rk);
    exp_t e;
    e.gnt = g; e.idx = i; e.valid = v; e.done = dn; e.rank = rk;
    return e;
  endfunction

  task automatic step(input string name, input stim_t s, input exp_t e);
    exp_t got;
    exp_t want;
    @(negedge clk);
    rstn       = s.rstn;
    req        = s.req;
    last       = s.last;
    down_ready = s.dr;
    lru_en     = s.lru;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = {gnt, gnt_idx, gnt_valid, xfer_done, rank_o};
    want = sb.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b done=%b rank=%h, expected gnt=%b idx=%0d valid=%b done=%b rank=%h",
               name, got.gnt, got.idx, got.valid, got.done, got.rank,
               want.gnt, want.idx, want.valid, want.done, want.rank);
    end
  endtask

  initial begin
    int          g  [6] = '{3, 2, 1, 0, 3, 2};
    logic [15:0] ra [6] = '{16'h1842, 16'h2184, 16'h4218, 16'h8421, 16'h1842, 16'h2184};
    logic [15:0] rb;

    rstn = 1'b0; req = '0; last = '0; down_ready = 1'b0; lru_en = 1'b1;

    //                   rstn req      last     dr    lru        gnt      idx v     done  rank
    tbl.push_back('{S(0, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8421)});
    tbl.push_back('{S(1, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8421)});
    tbl.push_back('{S(1, 4'b0101, 4'b0000, 0, 1), E(4'b0100, 2, 1, 0, 16'h8421)});
    tbl.push_back('{S(1, 4'b0101, 4'b0100, 1, 1), E(4'b0000, 0, 0, 1, 16'h8142)});
    tbl.push_back('{S(1, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8142)});
    // requester 1 multi-beat burst, ready pattern 1,0,1,0,1
    tbl.push_back('{S(1, 4'b0011, 4'b0000, 0, 1), E(4'b0010, 1, 1, 0, 16'h8142)});
    tbl.push_back('{S(1, 4'b1111, 4'b0000, 1, 1), E(4'b0010, 1, 1, 0, 16'h8142)});
    tbl.push_back('{S(1, 4'b1111, 4'b0000, 0, 1), E(4'b0010, 1, 1, 0, 16'h8142)});
    tbl.push_back('{S(1, 4'b1111, 4'b0000, 1, 1), E(4'b0010, 1, 1, 0, 16'h8142)});
    tbl.push_back('{S(1, 4'b1111, 4'b0010, 0, 1), E(4'b0010, 1, 1, 0, 16'h8142)});
    tbl.push_back('{S(1, 4'b1111, 4'b0010, 1, 1), E(4'b0000, 0, 0, 1, 16'h8214)});
    tbl.push_back('{S(1, 4'b1111, 4'b0000, 0, 1), E(4'b1000, 3, 1, 0, 16'h8214)});
    // lru_en low in the burst-end cycle: ranks stay put
    tbl.push_back('{S(1, 4'b1111, 4'b1000, 1, 0), E(4'b0000, 0, 0, 1, 16'h8214)});
    tbl.push_back('{S(1, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8214)});
    // owner drops req mid-burst: grant held, others ignored
    tbl.push_back('{S(1, 4'b0100, 4'b0000, 0, 1), E(4'b0100, 2, 1, 0, 16'h8214)});
    tbl.push_back('{S(1, 4'b0000, 4'b0100, 1, 1), E(4'b0100, 2, 1, 0, 16'h8214)});
    tbl.push_back('{S(1, 4'b1011, 4'b1111, 1, 1), E(4'b0100, 2, 1, 0, 16'h8214)});
    tbl.push_back('{S(1, 4'b0100, 4'b0100, 1, 1), E(4'b0000, 0, 0, 1, 16'h8124)});
    tbl.push_back('{S(1, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8124)});
    // reset during beat 2 of a grant to requester 2
    tbl.push_back('{S(1, 4'b0100, 4'b0000, 0, 1), E(4'b0100, 2, 1, 0, 16'h8124)});
    tbl.push_back('{S(1, 4'b0100, 4'b0000, 1, 1), E(4'b0100, 2, 1, 0, 16'h8124)});
    tbl.push_back('{S(0, 4'b0100, 4'b0100, 1, 1), E(4'b0000, 0, 0, 0, 16'h8421)});
    tbl.push_back('{S(1, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8421)});

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].s, tbl[k].e);

    // fairness: all requesting, single-beat bursts, LRU on
    step("fair_rst", S(0, 4'b0000, 4'b0000, 0, 1), E(4'b0000, 0, 0, 0, 16'h8421));
    rb = 16'h8421;
    for (int k = 0; k < 6; k++) begin
      step($sformatf("fair_gnt%0d", k), S(1, 4'b1111, 4'b1111, 1, 1),
           E(4'b0001 << g[k], 2'(g[k]), 1, 0, rb));
      step($sformatf("fair_end%0d", k), S(1, 4'b1111, 4'b1111, 1, 1),
           E(4'b0000, 0, 0, 1, ra[k]));
      rb = ra[k];
    end

    // fixed priority: requester 3 always wins, ranks frozen
    step("fix_rst", S(0, 4'b0000, 4'b0000, 0, 0), E(4'b0000, 0, 0, 0, 16'h8421));
    for (int k = 0; k < 3; k++) begin
      step($sformatf("fix_gnt%0d", k), S(1, 4'b1001, 4'b1111, 1, 0),
           E(4'b1000, 3, 1, 0, 16'h8421));
      step($sformatf("fix_end%0d", k), S(1, 4'b1001, 4'b1111, 1, 0),
           E(4'b0000, 0, 0, 1, 16'h8421));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
